switch_allocator: RTL and testbench

Wormhole switch allocator for the 5-port mesh router. Takes the per-input one-hot output-port request produced by the XY route computation, arbitrates each output port among competing inputs with a round-robin policy, and locks the winning input to that output from head flit through tail flit. Drives the crossbar select lines and per-input flow-control ready signals; sits between the input buffers/route stage and the crossbar.

---
 rtl/noc_pkg.sv | 24 ++
 rtl/switch_allocator_rr_arbiter.sv | 30 +++
 rtl/switch_allocator.sv | 134 +++++++++++++
 tb/tb_switch_allocator.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: port count and indices, crossbar select width,
// per-output lock state encoding and the round-robin pointer increment helper.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int SEL_W  = 3;

  localparam int PORT_E = 0;
  localparam int PORT_W = 1;
  localparam int PORT_N = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } out_state_t;

  // Port index + 1, wrapping the last port back to 0.
  function automatic logic [SEL_W-1:0] next_port(input logic [SEL_W-1:0] p);
    return (p == SEL_W'(NPORTS - 1)) ? '0 : p + SEL_W'(1);
  endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin picker: first asserted request scanning upward from ptr, wrapping
// past the last port. Produces a one-hot grant plus the winning index.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic [NPORTS-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NPORTS-1:0] grant,
  output logic [SEL_W-1:0]  idx
);

  int c;

  // Walk from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    c     = 0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NPORTS) c = c - NPORTS;
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration with head-to-tail
// locking. Define SA_FAST_RELEASE_EN to re-arbitrate in the tail cycle (no bubble).
//
// state      | meaning
// OUT_IDLE   | output free; arbitrates among head-flit requesters
// OUT_LOCKED | output owned by owner_q; transfers when owner valid and downstream ready
module switch_allocator #(
  parameter int NPORTS = 5,
  parameter int SEL_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NPORTS-1:0]         in_valid,
  input  logic [NPORTS-1:0]         in_head,
  input  logic [NPORTS-1:0]         in_tail,
  input  logic [NPORTS*NPORTS-1:0]  in_route,
  input  logic [NPORTS-1:0]         out_ready,
  output logic [NPORTS-1:0]         in_ready,
  output logic [NPORTS-1:0]         out_valid,
  output logic [NPORTS*SEL_W-1:0]   xbar_sel,
  output logic [NPORTS-1:0]         out_locked
);
  import noc_pkg::*;

  out_state_t       state_q [NPORTS];
  out_state_t       state_d [NPORTS];
  logic [SEL_W-1:0] owner_q [NPORTS];
  logic [SEL_W-1:0] owner_d [NPORTS];
  logic [SEL_W-1:0] ptr_q   [NPORTS];
  logic [SEL_W-1:0] ptr_d   [NPORTS];

  logic [NPORTS-1:0] is_owner;
  logic [NPORTS-1:0] route_low [NPORTS];
  logic [NPORTS-1:0] req_out   [NPORTS];
  logic [NPORTS-1:0] win_gnt   [NPORTS];
  logic [SEL_W-1:0]  win_idx   [NPORTS];
  logic [SEL_W-1:0]  arb_ptr   [NPORTS];
  logic [NPORTS-1:0] fire;
  logic [NPORTS-1:0] tail_fire;

  // An input holding a lock never requests again until its tail leaves.
  always_comb begin
    is_owner = '0;
    for (int o = 0; o < NPORTS; o++)
      if (state_q[o] == OUT_LOCKED) is_owner[owner_q[o]] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NPORTS; i++)
      route_low[i] = in_route[NPORTS*i +: NPORTS] & (~in_route[NPORTS*i +: NPORTS] + NPORTS'(1));
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        req_out[o][i] = in_valid[i] & in_head[i] & ~is_owner[i] & route_low[i][o];
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      fire[o]      = (state_q[o] == OUT_LOCKED) & in_valid[owner_q[o]] & out_ready[o];
      tail_fire[o] = fire[o] & in_tail[owner_q[o]];
`ifdef SA_FAST_RELEASE_EN
      arb_ptr[o]   = (state_q[o] == OUT_LOCKED) ? next_port(owner_q[o]) : ptr_q[o];
`else
      arb_ptr[o]   = ptr_q[o];
`endif
    end
  end

  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arbiter u_arb (
      .req   (req_out[o]),
      .ptr   (arb_ptr[o]),
      .grant (win_gnt[o]),
      .idx   (win_idx[o])
    );
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NPORTS; o++) begin
      if (reset) begin
        state_q[o] <= OUT_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end else begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      case (state_q[o])
        OUT_IDLE: begin
          if (|win_gnt[o]) begin
            state_d[o] = OUT_LOCKED;
            owner_d[o] = win_idx[o];
          end
        end
        OUT_LOCKED: begin
          if (tail_fire[o]) begin
            ptr_d[o]   = next_port(owner_q[o]);
            state_d[o] = OUT_IDLE;
            owner_d[o] = '0;
`ifdef SA_FAST_RELEASE_EN
            if (|win_gnt[o]) begin
              state_d[o] = OUT_LOCKED;
              owner_d[o] = win_idx[o];
            end
`endif
          end
        end
        default: state_d[o] = OUT_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready   = '0;
    out_valid  = '0;
    out_locked = '0;
    xbar_sel   = '0;
    for (int o = 0; o < NPORTS; o++) begin
      out_valid[o]  = fire[o];
      out_locked[o] = (state_q[o] == OUT_LOCKED);
      if (state_q[o] == OUT_LOCKED) xbar_sel[SEL_W*o +: SEL_W] = owner_q[o];
      if (fire[o]) in_ready[owner_q[o]] = 1'b1;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: packet sources per input, a per-cycle reference model
// of the lock/round-robin rules, and directed literal checks per scenario.
module tb_switch_allocator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  in_valid, in_head, in_tail, out_ready;
  logic [24:0] in_route;
  logic [4:0]  in_ready, out_valid, out_locked;
  logic [14:0] xbar_sel;

  switch_allocator #(.NPORTS(5), .SEL_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_head(in_head),
    .in_tail(in_tail), .in_route(in_route), .out_ready(out_ready),
    .in_ready(in_ready), .out_valid(out_valid), .xbar_sel(xbar_sel),
    .out_locked(out_locked)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packet sources: remaining flits, packet length, destination, extra route bits.
  int         rem [5];
  int         tot [5];
  int         dst [5];
  logic [4:0] extra [5];
  logic [4:0] ordy;
  logic       rst_req;
  logic [4:0] rdy_s;

  task automatic drive();
    reset     = rst_req;
    out_ready = ordy;
    for (int i = 0; i < 5; i++) begin
      in_valid[i] = (rem[i] > 0);
      in_head[i]  = (rem[i] > 0) && (rem[i] == tot[i]);
      in_tail[i]  = (rem[i] == 1);
      in_route[5*i +: 5] = (rem[i] > 0) ? ((5'b00001 << dst[i]) | extra[i]) : 5'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      if (rdy_s[i] && rem[i] > 0) rem[i]--;
    drive();
    @(negedge clk);
    rdy_s = in_ready;
  endtask

  task automatic load(input int i, input int n, input int d, input logic [4:0] x);
    rem[i] = n; tot[i] = n; dst[i] = d; extra[i] = x;
  endtask

  // Reference model: owner per output (-1 = free) and round-robin start per output.
  int         m_own [5];
  int         m_ptr [5];
  int         m_nxt [5];
  int         m_want [5];
  bit         m_fire [5];
  bit         m_owns [5];
  logic [4:0] e_rdy, e_val, e_lock;
  logic [14:0] e_sel;
  bit         chk_en = 1'b0;

  function automatic int pick(input int o, input int start, input int want[5]);
    for (int k = 0; k < 5; k++) begin
      int i = (start + k) % 5;
      if (want[i] == o) return i;
    end
    return -1;
  endfunction

  // Grant events observed on the DUT: o*10 + input, in order.
  int         glog [$];
  int         f2 [$];
  logic [4:0] prev_lock = '0;
  logic [4:0] prev_tf = '0;

  initial for (int o = 0; o < 5; o++) begin m_own[o] = -1; m_ptr[o] = 0; end

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) m_owns[i] = 1'b0;
    for (int o = 0; o < 5; o++) if (m_own[o] >= 0) m_owns[m_own[o]] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_want[i] = -1;
      if (in_valid[i] && in_head[i] && !m_owns[i])
        for (int b = 4; b >= 0; b--) if (in_route[5*i + b]) m_want[i] = b;
    end
    e_rdy = '0; e_val = '0; e_lock = '0; e_sel = '0;
    for (int o = 0; o < 5; o++) begin
      m_fire[o] = 1'b0;
      if (m_own[o] >= 0) begin
        e_lock[o] = 1'b1;
        e_sel[3*o +: 3] = 3'(m_own[o]);
        if (in_valid[m_own[o]] && out_ready[o]) begin
          m_fire[o] = 1'b1;
          e_val[o] = 1'b1;
          e_rdy[m_own[o]] = 1'b1;
        end
      end
    end
    if (chk_en) begin
      chk("model_in_ready", 32'(in_ready), 32'(e_rdy));
      chk("model_out_valid", 32'(out_valid), 32'(e_val));
      chk("model_out_locked", 32'(out_locked), 32'(e_lock));
      chk("model_xbar_sel", 32'(xbar_sel), 32'(e_sel));
      for (int o = 0; o < 5; o++)
        if (out_locked[o] && (!prev_lock[o] || prev_tf[o])) glog.push_back(o*10 + int'(xbar_sel[3*o +: 3]));
      if (out_valid[2]) f2.push_back(int'(xbar_sel[8:6]));
      for (int o = 0; o < 5; o++) prev_tf[o] = out_valid[o] & in_tail[xbar_sel[3*o +: 3]];
      prev_lock = out_locked;
    end
    for (int o = 0; o < 5; o++) begin
      m_nxt[o] = m_own[o];
      if (m_own[o] >= 0) begin
        if (m_fire[o] && in_tail[m_own[o]]) begin
          m_ptr[o] = (m_own[o] + 1) % 5;
          m_nxt[o] = -1;
`ifdef SA_FAST_RELEASE_EN
          m_nxt[o] = pick(o, m_ptr[o], m_want);
`endif
        end
      end else begin
        m_nxt[o] = pick(o, m_ptr[o], m_want);
      end
    end
    for (int o = 0; o < 5; o++) m_own[o] = m_nxt[o];
    if (reset) begin
      for (int o = 0; o < 5; o++) begin m_own[o] = -1; m_ptr[o] = 0; end
      chk_en = 1'b1;
    end
  end

  function automatic int code(input int q[$]);
    int c = 0;
    foreach (q[k]) c = c*100 + q[k];
    return c;
  endfunction

  task automatic settle();
    repeat (3) cycle();
    glog.delete();
    f2.delete();
  endtask

  int first_f, last_f, cyc;

  initial begin
    for (int i = 0; i < 5; i++) begin rem[i] = 0; tot[i] = 0; dst[i] = 0; extra[i] = '0; end
    ordy = 5'h1f; rst_req = 1'b1; rdy_s = '0;
    drive();
    repeat (3) cycle();
    rst_req = 1'b0;
    cycle();
    chk("reset_locked", 32'(out_locked), 32'h0);
    chk("reset_ready", 32'(in_ready), 32'h0);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_xbar", 32'(xbar_sel), 32'h0);
    glog.delete(); f2.delete();

    // single-flit packet, input 4 to E
    load(4, 1, 0, 5'b0);
    cycle();
    chk("s1_pre_lock", 32'(out_locked), 32'h0);
    cycle();
    chk("s1_locked", 32'(out_locked), 32'b00001);
    chk("s1_in_ready", 32'(in_ready), 32'b10000);
    chk("s1_xbar_e", 32'(xbar_sel[2:0]), 32'd4);
    cycle();
    chk("s1_released", 32'(out_locked), 32'h0);
    chk("s1_grants", 32'(code(glog)), 32'd4);
    settle();

    // inputs 1 and 3 contend for N with 3-flit packets
    load(1, 3, 2, 5'b0);
    load(3, 3, 2, 5'b0);
    repeat (12) cycle();
    chk("s2_grants", 32'(code(glog)), 32'd2123);
    chk("s2_flit_order", 32'(f2.size() == 6 ? (f2[0]*100000 + f2[1]*10000 + f2[2]*1000 + f2[3]*100 + f2[4]*10 + f2[5]) : -1), 32'd111333);
    settle();

    // repeated contention on Eject
    load(0, 1, 4, 5'b0);
    load(2, 1, 4, 5'b0);
    load(4, 1, 4, 5'b0);
    begin
      bit reloaded = 1'b0;
      repeat (14) begin
        cycle();
        if (rem[0] == 0 && !reloaded) begin load(0, 1, 4, 5'b0); reloaded = 1'b1; end
      end
    end
    chk("s3_grants", 32'(code(glog)), 32'd40424440);
    settle();

    // stall S mid-packet while input 1 waits for S
    load(0, 3, 3, 5'b0);
    cycle();
    cycle();
    ordy[3] = 1'b0;
    load(1, 1, 3, 5'b0);
    repeat (4) begin
      cycle();
      chk("s4_hold_locked", 32'(out_locked[3]), 32'h1);
      chk("s4_hold_valid", 32'(out_valid[3]), 32'h0);
      chk("s4_hold_owner", 32'(xbar_sel[11:9]), 32'd0);
    end
    ordy[3] = 1'b1;
    repeat (10) cycle();
    chk("s4_grants", 32'(code(glog)), 32'd3031);
    settle();

    // parallel grants to N and S
    load(0, 2, 2, 5'b0);
    load(1, 2, 3, 5'b0);
    cycle();
    cycle();
    chk("s5_locked", 32'(out_locked[3:2]), 32'b11);
    chk("s5_valid", 32'(out_valid[3:2]), 32'b11);
    chk("s5_ready", 32'(in_ready[1:0]), 32'b11);
    chk("s5_sel_n", 32'(xbar_sel[8:6]), 32'd0);
    chk("s5_sel_s", 32'(xbar_sel[11:9]), 32'd1);
    settle();

    // multi-bit route takes the lowest bit
    load(2, 1, 2, 5'b10000);
    cycle();
    cycle();
    chk("s6_multibit_lock", 32'(out_locked), 32'b00100);
    chk("s6_multibit_ready", 32'(in_ready), 32'b00100);
    settle();

    // body flit at an input owning nothing is ignored
    rem[0] = 2; tot[0] = 3; dst[0] = 1; extra[0] = '0;
    repeat (3) begin
      cycle();
      chk("s6_nonhead_lock", 32'(out_locked), 32'h0);
      chk("s6_nonhead_ready", 32'(in_ready), 32'h0);
    end
    rem[0] = 0;
    settle();

    // reset mid-packet drops the lock
    load(1, 4, 0, 5'b0);
    repeat (3) cycle();
    chk("s7_locked_before", 32'(out_locked), 32'b00001);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    chk("s7_reset_lock", 32'(out_locked), 32'h0);
    chk("s7_reset_ready", 32'(in_ready), 32'h0);
    rem[1] = 0;
    settle();

    // back-to-back 2-flit packets on W
    load(0, 2, 1, 5'b0);
    load(1, 2, 1, 5'b0);
    first_f = -1; last_f = -1; cyc = 0;
    repeat (12) begin
      cycle();
      cyc++;
      if (out_valid[1]) begin
        if (first_f < 0) first_f = cyc;
        last_f = cyc;
      end
    end
    chk("s8_grants", 32'(code(glog)), 32'd1011);
`ifdef SA_FAST_RELEASE_EN
    chk("s8_span", 32'(last_f - first_f + 1), 32'd4);
`else
    chk("s8_span", 32'(last_f - first_f + 1), 32'd5);
`endif
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
